uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_level.sv | 41 ++++
 rtl/uart_rx_ctrl.sv | 155 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: register map, STATUS/CTRL
// bit positions and the read-sequencer state encoding.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_LEVEL_LSB = 1;
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_THR_LSB   = 1;

    localparam logic [31:0] DATA_EMPTY_WORD = 32'h8000_0000;

    // Upper STATUS bits sit just above the (w+1)-bit level field.
    function automatic int stat_full_bit(input int w);
        return w + 2;
    endfunction

    function automatic int stat_ovr_bit(input int w);
        return w + 3;
    endfunction

    function automatic int stat_to_bit(input int w);
        return w + 4;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_POP    = 2'd1,
        ST_SETTLE = 2'd2
    } rx_state_e;

endpackage

// File: rtl/uart_rx_level.sv
// FIFO occupancy tracker: mirrors the FIFO fill level from push/pop strobes and
// flags a sticky overrun when the receiver pushes into a full FIFO.
module uart_rx_level #(
    parameter int W = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    input  logic       clr_ovr,
    output logic [W:0] level,
    output logic       full,
    output logic       overrun
);

    localparam logic [W:0] DEPTH = {1'b1, {W{1'b0}}};

    assign full = (level == DEPTH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
        end else if (push && !pop && !full) begin
            level <= level + 1'b1;
        end else if (pop && !push && level != '0) begin
            level <= level - 1'b1;
        end
    end

    // A set in the same cycle as a software clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (push && full && !pop) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive-side bus controller: DATA/STATUS/CTRL registers, FIFO pop sequencing
// and level interrupt. Define UART_RX_TIMEOUT_EN to add the idle-receive timeout.
module uart_rx_ctrl #(
    parameter int B           = 8,
    parameter int W           = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cs,
    input  logic          we,
    input  logic [1:0]    addr,
    input  logic [31:0]   wdata,
    output logic          ready,
    output logic          rvalid,
    output logic [31:0]   rdata,
    input  logic          rx_push,
    input  logic          fifo_empty,
    input  logic [B-1:0]  fifo_rdata,
    output logic          fifo_rd,
    output logic          irq
);

    import uart_pkg::*;

    localparam int FULL_BIT = stat_full_bit(W);
    localparam int OVR_BIT  = stat_ovr_bit(W);
    localparam int TO_BIT   = stat_to_bit(W);

    rx_state_e   state_q, state_d;
    logic        accept, rd_acc, wr_acc;
    logic        clr_ovr, clr_to;
    logic [W:0]  level;
    logic        full, overrun, timeout;
    logic        ctrl_en;
    logic [W:0]  ctrl_thr;
    logic [31:0] status_word, ctrl_word, rd_word;

    assign accept  = cs && ready;
    assign rd_acc  = accept && !we;
    assign wr_acc  = accept && we;
    assign clr_ovr = wr_acc && (addr == REG_STATUS) && wdata[OVR_BIT];
    assign clr_to  = wr_acc && (addr == REG_STATUS) && wdata[TO_BIT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // The pop lands in the cycle rdata is presented; SETTLE lets the FIFO head update.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        fifo_rd = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (cs && !we && addr == REG_DATA && !fifo_empty) state_d = ST_POP;
            end
            ST_POP: begin
                fifo_rd = 1'b1;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    uart_rx_level #(.W(W)) u_level (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rx_push),
        .pop     (fifo_rd),
        .clr_ovr (clr_ovr),
        .level   (level),
        .full    (full),
        .overrun (overrun)
    );

`ifdef UART_RX_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] to_cnt;
    logic             to_hit;

    assign to_hit = (to_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (rx_push || fifo_rd || level == '0) to_cnt <= '0;
            else if (!to_hit)                      to_cnt <= to_cnt + 1'b1;
            if (to_hit)      timeout <= 1'b1;
            else if (clr_to) timeout <= 1'b0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        status_word                           = '0;
        status_word[STAT_EMPTY_BIT]           = fifo_empty;
        status_word[STAT_LEVEL_LSB +: W+1]    = level;
        status_word[FULL_BIT]                 = full;
        status_word[OVR_BIT]                  = overrun;
        status_word[TO_BIT]                   = timeout;
        ctrl_word                             = '0;
        ctrl_word[CTRL_EN_BIT]                = ctrl_en;
        ctrl_word[CTRL_THR_LSB +: W+1]        = ctrl_thr;
    end

    always_comb begin
        rd_word = '0;
        case (addr)
            REG_DATA:   rd_word = fifo_empty ? DATA_EMPTY_WORD : 32'(fifo_rdata);
            REG_STATUS: rd_word = status_word;
            REG_CTRL:   rd_word = ctrl_word;
            REG_RSVD:   rd_word = '0;
            default:    rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= rd_acc;
            if (rd_acc) rdata <= rd_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en  <= 1'b0;
            ctrl_thr <= '0;
        end else if (wr_acc && addr == REG_CTRL) begin
            ctrl_en  <= wdata[CTRL_EN_BIT];
            ctrl_thr <= wdata[CTRL_THR_LSB +: W+1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq <= 1'b0;
        else          irq <= ctrl_en && ((ctrl_thr != '0 && level >= ctrl_thr) || overrun || timeout);
    end

    logic unused_ok;
    assign unused_ok = ^{wdata, clr_to, TIMEOUT_CYC};

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized self-checking bench for uart_rx_ctrl; a queue-based FIFO model supplies
// the FIFO side and predicts level, sticky flags, CTRL contents and irq.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int B     = 8;
    localparam int W     = 4;
    localparam int DEPTH = 16;
    localparam int TCYC  = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cs = 1'b0, we = 1'b0;
    logic [1:0]    addr = 2'd0;
    logic [31:0]   wdata = '0;
    logic          ready, rvalid, fifo_rd, irq;
    logic [31:0]   rdata;
    logic          rx_push = 1'b0;
    logic [B-1:0]  push_data = '0;
    logic          fifo_empty = 1'b1;
    logic [B-1:0]  fifo_rdata = '0;

    int checks = 0;
    int errors = 0;

    // Behavioural environment + reference state
    logic [B-1:0] q[$];
    logic         exp_ovr = 1'b0, exp_to = 1'b0, exp_en = 1'b0, exp_irq = 1'b0;
    logic [W:0]   exp_thr = '0;
    int           idle_cnt = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.B(B), .W(W), .TIMEOUT_CYC(TCYC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cs         (cs),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .ready      (ready),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .rx_push    (rx_push),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .irq        (irq)
    );

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            exp_ovr = 1'b0; exp_to = 1'b0; exp_en = 1'b0; exp_thr = '0; exp_irq = 1'b0;
            idle_cnt = 0;
            fifo_empty <= 1'b1;
            fifo_rdata <= '0;
        end else begin
            bit do_pop, do_push, stat_wr, ctrl_wr;
            do_pop  = fifo_rd && q.size() > 0;
            do_push = rx_push && (q.size() < DEPTH || do_pop);
            stat_wr = cs && we && addr == 2'd1;
            ctrl_wr = cs && we && addr == 2'd2;
            exp_irq = exp_en && ((exp_thr != 0 && q.size() >= int'(exp_thr)) || exp_ovr || exp_to);
`ifdef UART_RX_TIMEOUT_EN
            if (idle_cnt == TCYC - 1)        exp_to = 1'b1;
            else if (stat_wr && wdata[W+4])  exp_to = 1'b0;
            if (rx_push || fifo_rd || q.size() == 0) idle_cnt = 0;
            else if (idle_cnt < TCYC - 1)            idle_cnt++;
`endif
            if (rx_push && q.size() == DEPTH && !do_pop) exp_ovr = 1'b1;
            else if (stat_wr && wdata[W+3])              exp_ovr = 1'b0;
            if (ctrl_wr) begin
                exp_en  = wdata[0];
                exp_thr = wdata[W+1:1];
            end
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(push_data);
            fifo_empty <= (q.size() == 0);
            fifo_rdata <= (q.size() > 0) ? q[0] : '0;
        end
    end

    function automatic logic [31:0] exp_status();
        int n;
        logic [31:0] s;
        n = q.size();
        s = '0;
        s[0]     = (n == 0);
        s[W+1:1] = n[W:0];
        s[W+2]   = (n == DEPTH);
        s[W+3]   = exp_ovr;
        s[W+4]   = exp_to;
        return s;
    endfunction

    function automatic logic [31:0] exp_data();
        return (q.size() == 0) ? 32'h8000_0000 : {24'h0, q[0]};
    endfunction

    // ---------------- drivers ----------------
    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 50) begin @(negedge clk); n++; end
        if (!ready) begin
            errors++;
            $display("FAIL ready_wait got ready=%0b exp 1 within 50 cycles", ready);
        end
        checks++;
    endtask

    task automatic bus_read(input logic [1:0] a, input bit push_in_pop, input logic [7:0] pv,
                            output logic [31:0] d, output logic rv, output int busy, output int pops);
        @(negedge clk);
        wait_ready();
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0;
        d = rdata; rv = rvalid; busy = 0; pops = 0;
        for (int i = 0; i < 4; i++) begin
            if (ready) break;
            busy++;
            if (fifo_rd) pops++;
            if (i == 0 && push_in_pop) begin rx_push = 1'b1; push_data = pv; end
            @(negedge clk);
            rx_push = 1'b0;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        wait_ready();
        cs = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic push_byte(input logic [7:0] v);
        @(negedge clk);
        rx_push = 1'b1; push_data = v;
        @(negedge clk);
        rx_push = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; cs = 1'b0; we = 1'b0; rx_push = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d; logic rv; int busy, pops;
        @(negedge clk);
        if ({ready, rvalid, fifo_rd, irq} !== 4'b1000) begin
            errors++; $display("FAIL reset_outputs got rdy/rv/rd/irq=%b exp 1000", {ready, rvalid, fifo_rd, irq});
        end
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        checks++;
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd1, 1'b0, 8'h0, d, rv, busy, pops);
        if (d !== 32'h1) begin errors++; $display("FAIL reset_status got %h exp 00000001", d); end
        checks++;
        bus_read(2'd2, 1'b0, 8'h0, d, rv, busy, pops);
        if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", d); end
        checks++;
    endtask

    task automatic test_fifo_order();
        logic [31:0] d; logic rv; int busy, pops;
        logic [7:0] vals [3] = '{8'h41, 8'h42, 8'h43};
        do_reset();
        foreach (vals[i]) push_byte(vals[i]);
        foreach (vals[i]) begin
            bus_read(2'd0, 1'b0, 8'h0, d, rv, busy, pops);
            if (d !== {24'h0, vals[i]} || rv !== 1'b1) begin
                errors++; $display("FAIL order_data%0d got %h rv=%0b exp %h rv=1", i, d, rv, vals[i]);
            end
            checks++;
            if (busy != 2 || pops != 1) begin
                errors++; $display("FAIL order_handshake%0d got busy=%0d pops=%0d exp 2/1", i, busy, pops);
            end
            checks++;
        end
        bus_read(2'd1, 1'b0, 8'h0, d, rv, busy, pops);
        if (d !== 32'h1) begin errors++; $display("FAIL order_level got %h exp 00000001", d); end
        checks++;
    endtask

    task automatic test_empty_read();
        logic [31:0] d; logic rv; int busy, pops;
        do_reset();
        bus_read(2'd0, 1'b0, 8'h0, d, rv, busy, pops);
        if (d !== 32'h8000_0000 || rv !== 1'b1) begin
            errors++; $display("FAIL empty_data got %h rv=%0b exp 80000000 rv=1", d, rv);
        end
        checks++;
        if (busy != 0 || pops != 0) begin
            errors++; $display("FAIL empty_nopop got busy=%0d pops=%0d exp 0/0", busy, pops);
        end
        checks++;
    endtask

    task automatic test_overrun();
        logic [31:0] d; logic rv; int busy, pops;
        logic [7:0] first;
        do_reset();
        first = 8'($urandom_range(0, 255));
        push_byte(first);
        for (int i = 1; i < 17; i++) push_byte(8'($urandom_range(0, 255)));
        bus_read(2'd1, 1'b0, 8'h0, d, rv, busy, pops);
        if (d !== 32'h0000_00E0) begin errors++; $display("FAIL ovr_status got %h exp 000000e0", d); end
        checks++;
        bus_write(2'd1, 32'h0000_007F);
        bus_read(2'd1, 1'b0, 8'h0, d, rv, busy, pops);
        if (d !== 32'h0000_00E0) begin errors++; $display("FAIL ovr_ignored_bits got %h exp 000000e0", d); end
        checks++;
        bus_write(2'd1, 32'h0000_0080);
        bus_read(2'd1, 1'b0, 8'h0, d, rv, busy, pops);
        if (d !== 32'h0000_0060) begin errors++; $display("FAIL ovr_clear got %h exp 00000060", d); end
        checks++;
        bus_read(2'd0, 1'b0, 8'h0, d, rv, busy, pops);
        if (d !== {24'h0, first}) begin errors++; $display("FAIL ovr_head got %h exp %h", d, first); end
        checks++;
    endtask

    task automatic test_ctrl_regs();
        logic [31:0] d; logic rv; int busy, pops;
        do_reset();
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd2, 1'b0, 8'h0, d, rv, busy, pops);
        if (d !== 32'h0000_003F) begin errors++; $display("FAIL ctrl_mask got %h exp 0000003f", d); end
        checks++;
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, 1'b0, 8'h0, d, rv, busy, pops);
        if (d !== 32'h0 || rv !== 1'b1) begin errors++; $display("FAIL rsvd_read got %h rv=%0b exp 0 rv=1", d, rv); end
        checks++;
        bus_read(2'd1, 1'b0, 8'h0, d, rv, busy, pops);
        if (d !== 32'h1) begin errors++; $display("FAIL ignored_writes got %h exp 00000001", d); end
        checks++;
    endtask

    task automatic test_irq_threshold();
        logic [31:0] d; logic rv; int busy, pops;
        do_reset();
        bus_write(2'd2, 32'h9);
        for (int i = 0; i < 3; i++) push_byte(8'(8'h10 + i));
        @(negedge clk);
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_below got %0b exp 0", irq); end
        checks++;
        push_byte(8'h13);
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag got %0b exp 0", irq); end
        checks++;
        @(negedge clk);
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %0b exp 1", irq); end
        checks++;
        bus_read(2'd0, 1'b0, 8'h0, d, rv, busy, pops);
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got %0b exp 0", irq); end
        checks++;
    endtask

    task automatic test_simul_push_pop();
        logic [31:0] d; logic rv; int busy, pops;
        do_reset();
        for (int i = 0; i < 5; i++) push_byte(8'(8'h50 + i));
        bus_read(2'd0, 1'b1, 8'hAA, d, rv, busy, pops);
        if (d !== 32'h50 || pops != 1) begin errors++; $display("FAIL simul_data got %h pops=%0d exp 50/1", d, pops); end
        checks++;
        bus_read(2'd1, 1'b0, 8'h0, d, rv, busy, pops);
        if (d !== 32'h0000_000A) begin errors++; $display("FAIL simul_level got %h exp 0000000a", d); end
        checks++;
    endtask

    task automatic test_reset_mid_pop();
        logic [31:0] d; logic rv; int busy, pops;
        do_reset();
        push_byte(8'h33);
        push_byte(8'h34);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = 2'd0;
        @(negedge clk);
        cs = 1'b0;
        reset_n = 1'b0;
        #1;
        if ({ready, rvalid, fifo_rd, irq} !== 4'b1000) begin
            errors++; $display("FAIL midpop_reset got rdy/rv/rd/irq=%b exp 1000", {ready, rvalid, fifo_rd, irq});
        end
        checks++;
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd1, 1'b0, 8'h0, d, rv, busy, pops);
        if (d !== 32'h1) begin errors++; $display("FAIL midpop_status got %h exp 00000001", d); end
        checks++;
    endtask

`ifdef UART_RX_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] d; logic rv; int busy, pops;
        do_reset();
        bus_write(2'd2, 32'h1);
        push_byte(8'h77);
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (i == 16 && irq !== 1'b0) begin errors++; $display("FAIL to_early got %0b exp 0", irq); end
            if (i == 17 && irq !== 1'b1) begin errors++; $display("FAIL to_irq got %0b exp 1", irq); end
        end
        checks += 2;
        bus_read(2'd1, 1'b0, 8'h0, d, rv, busy, pops);
        if (d !== 32'h0000_0102) begin errors++; $display("FAIL to_status got %h exp 00000102", d); end
        checks++;
    endtask
`endif

    task automatic test_random();
        logic [31:0] d, e; logic rv; int busy, pops, eb;
        do_reset();
        bus_write(2'd2, {26'h0, 6'($urandom_range(0, 63))});
        for (int n = 0; n < 300; n++) begin
            int op;
            @(negedge clk);
            if (irq !== exp_irq) begin errors++; $display("FAIL rnd_irq[%0d] got %0b exp %0b", n, irq, exp_irq); end
            checks++;
            op = $urandom_range(0, 11);
            if (op <= 4) begin
                push_byte(8'($urandom_range(0, 255)));
            end else if (op <= 7) begin
                e  = exp_data();
                eb = (q.size() == 0) ? 0 : 2;
                bus_read(2'd0, 1'b0, 8'h0, d, rv, busy, pops);
                if (d !== e || rv !== 1'b1 || busy != eb) begin
                    errors++; $display("FAIL rnd_data[%0d] got %h rv=%0b busy=%0d exp %h rv=1 busy=%0d", n, d, rv, busy, e, eb);
                end
                checks++;
            end else if (op == 8) begin
                e = exp_status();
                bus_read(2'd1, 1'b0, 8'h0, d, rv, busy, pops);
                if (d !== e) begin errors++; $display("FAIL rnd_status[%0d] got %h exp %h", n, d, e); end
                checks++;
            end else if (op == 9) begin
                e = {26'h0, exp_thr, exp_en};
                bus_read(2'd2, 1'b0, 8'h0, d, rv, busy, pops);
                if (d !== e) begin errors++; $display("FAIL rnd_ctrl[%0d] got %h exp %h", n, d, e); end
                checks++;
            end else if (op == 10) begin
                bus_write(2'd1, $urandom);
            end else begin
                bus_write(2'd2, $urandom);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_empty_read();
        test_overrun();
        test_ctrl_regs();
        test_irq_threshold();
        test_simul_push_pop();
        test_reset_mid_pop();
`ifdef UART_RX_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
